// File: rtl/reg_view_scanner.sv
`default_nettype none
// ============================================================================
// Module      : reg_view_scanner
// Description : Shows one of NUM_CH 16-bit debug channels on a 4-digit
//               multiplexed 7-segment display. Debounced buttons select and
//               freeze the channel.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_view_scanner #(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SCAN_CYCLES     = 50000,
    parameter int BANNER_CYCLES   = 25000000,
    localparam int CHW = ($clog2(NUM_CH) < 1) ? 1 : $clog2(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CH*16-1:0] ch_data,
    input  logic [3:0]           btn_n,
    output logic [7:0]           seg,
    output logic [3:0]           dig,
    output logic [CHW-1:0]       sel_ch,
    output logic                 frozen
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW  = $clog2(SCAN_CYCLES + 1);
    localparam int BW  = $clog2(BANNER_CYCLES + 1);
    localparam logic [6:0] C_GLYPH_C = 7'h46;
    localparam logic [6:0] C_BLANK   = 7'h7F;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    logic [3:0]     r_sync1, r_sync2, r_deb, r_armed, r_evt;
    logic [1:0]     r_started;
    logic [DBW-1:0] r_db_cnt [4];
    logic [3:0]     w_flip;

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            w_flip[b] = (r_sync2[b] != r_deb[b]) &&
                        (r_db_cnt[b] == DBW'(DEBOUNCE_CYCLES - 1));
        end
    end

    // A button only arms after it has been seen released once out of reset,
    // so a button held through reset cannot fire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1   <= 4'hF;
            r_sync2   <= 4'hF;
            r_deb     <= 4'hF;
            r_armed   <= 4'h0;
            r_evt     <= 4'h0;
            r_started <= 2'b00;
            for (int b = 0; b < 4; b++) r_db_cnt[b] <= '0;
        end else begin
            r_sync1   <= btn_n;
            r_sync2   <= r_sync1;
            r_started <= {r_started[0], 1'b1};
            for (int b = 0; b < 4; b++) begin
                if (r_sync2[b] == r_deb[b]) begin
                    r_db_cnt[b] <= '0;
                end else if (w_flip[b]) begin
                    r_db_cnt[b] <= '0;
                    r_deb[b]    <= r_sync2[b];
                end else begin
                    r_db_cnt[b] <= r_db_cnt[b] + 1'b1;
                end
            end
            r_armed <= r_armed | (r_sync2 & r_deb & {4{r_started[1]}});
            r_evt   <= w_flip & r_deb & r_armed;
        end
    end

    logic [CHW-1:0] r_sel, w_sel_nxt;
    logic           r_frozen, w_frz_nxt, w_sel_evt;
    logic [15:0]    r_snap, w_live, w_new, w_value;
    logic [BW-1:0]  r_banner;

    assign w_sel_evt = r_evt[0] | r_evt[1] | r_evt[3];
    assign w_frz_nxt = r_frozen ^ r_evt[2];

    always_comb begin
        w_sel_nxt = r_sel;
        if (r_evt[3])
            w_sel_nxt = '0;
        else if (r_evt[0])
            w_sel_nxt = (r_sel == CHW'(NUM_CH - 1)) ? '0 : r_sel + 1'b1;
        else if (r_evt[1])
            w_sel_nxt = (r_sel == '0) ? CHW'(NUM_CH - 1) : r_sel - 1'b1;
    end

    always_comb begin
        w_live = '0;
        w_new  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_sel == CHW'(k))     w_live = ch_data[k*16 +: 16];
            if (w_sel_nxt == CHW'(k)) w_new  = ch_data[k*16 +: 16];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel    <= '0;
            r_frozen <= 1'b0;
            r_snap   <= '0;
            r_banner <= '0;
        end else begin
            r_sel    <= w_sel_nxt;
            r_frozen <= w_frz_nxt;
            if (w_frz_nxt && (w_sel_evt || !r_frozen))
                r_snap <= w_new;
            if (w_sel_evt)
                r_banner <= BW'(BANNER_CYCLES);
            else if (r_banner != '0)
                r_banner <= r_banner - 1'b1;
        end
    end

    assign w_value = r_frozen ? r_snap : w_live;

    logic [SW-1:0] r_scan_cnt;
    logic [1:0]    r_scan_idx, r_dig_idx, w_out_idx;
    logic          r_upd, r_on, w_wrap, w_out_on, w_banner, w_dp_n;
    logic [7:0]    w_sel8;
    logic [6:0]    w_glyph;
    logic [7:0]    r_seg;
    logic [3:0]    r_dig;

    assign w_wrap    = (r_scan_cnt == SW'(SCAN_CYCLES - 1));
    // The digit enabled after each wrap is the one whose slot just elapsed.
    assign w_out_idx = r_upd ? (r_scan_idx - 2'd1) : r_dig_idx;
    assign w_out_on  = r_upd | r_on;
    assign w_banner  = (r_banner != '0);
    assign w_sel8    = 8'(r_sel);
    assign w_dp_n    = !(r_frozen && (w_out_idx == 2'd0));

    always_comb begin
        w_glyph = C_BLANK;
        case (w_out_idx)
            2'd0: w_glyph = w_banner ? hex7(w_sel8[3:0]) : hex7(w_value[3:0]);
            2'd1: w_glyph = w_banner ? hex7(w_sel8[7:4]) : hex7(w_value[7:4]);
            2'd2: w_glyph = w_banner ? C_BLANK           : hex7(w_value[11:8]);
            default: w_glyph = w_banner ? C_GLYPH_C      : hex7(w_value[15:12]);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scan_cnt <= '0;
            r_scan_idx <= 2'd0;
            r_dig_idx  <= 2'd0;
            r_upd      <= 1'b0;
            r_on       <= 1'b0;
            r_seg      <= 8'hFF;
            r_dig      <= 4'hF;
        end else begin
            if (w_wrap) begin
                r_scan_cnt <= '0;
                r_scan_idx <= r_scan_idx + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            r_upd <= w_wrap;
            if (r_upd) begin
                r_on      <= 1'b1;
                r_dig_idx <= w_out_idx;
            end
            if (w_out_on) begin
                r_seg <= {w_dp_n, w_glyph};
                r_dig <= ~(4'b0001 << w_out_idx);
            end
        end
    end

    assign seg    = r_seg;
    assign dig    = r_dig;
    assign sel_ch = r_sel;
    assign frozen = r_frozen;

endmodule
`default_nettype wire

// File: tb/tb_reg_view_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_view_scanner
// Description : Self-checking bench for reg_view_scanner with a display
//               scoreboard fed from a small behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_view_scanner;

    localparam int NUM_CH = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [47:0] ch_data;
    logic [3:0]  btn_n = 4'hF;
    logic [7:0]  seg;
    logic [3:0]  dig;
    logic [1:0]  sel_ch;
    logic        frozen;

    reg_view_scanner #(
        .NUM_CH          (NUM_CH),
        .DEBOUNCE_CYCLES (4),
        .SCAN_CYCLES     (2),
        .BANNER_CYCLES   (16)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .ch_data (ch_data),
        .btn_n   (btn_n),
        .seg     (seg),
        .dig     (dig),
        .sel_ch  (sel_ch),
        .frozen  (frozen)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] dig;
        logic [7:0] seg;
    } disp_t;

    disp_t       sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          m_sel = 0;
    logic        m_frozen = 1'b0;
    logic [15:0] m_snap = 16'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    function automatic logic [15:0] ch_word(input int k);
        return ch_data[k*16 +: 16];
    endfunction

    task automatic push_value();
        logic [15:0] v;
        v = m_frozen ? m_snap : ch_word(m_sel);
        sb_q.push_back({4'b1110, ~m_frozen, glyph(v[3:0])});
        sb_q.push_back({4'b1101, 1'b1, glyph(v[7:4])});
        sb_q.push_back({4'b1011, 1'b1, glyph(v[11:8])});
        sb_q.push_back({4'b0111, 1'b1, glyph(v[15:12])});
    endtask

    task automatic push_banner();
        logic [7:0] s8;
        s8 = 8'(m_sel);
        sb_q.push_back({4'b1110, ~m_frozen, glyph(s8[3:0])});
        sb_q.push_back({4'b1101, 1'b1, glyph(s8[7:4])});
        sb_q.push_back({4'b1011, 8'hFF});
        sb_q.push_back({4'b0111, 1'b1, 7'b1000110});
    endtask

    // Align to a fresh digit-0 slot, then compare one full scan.
    task automatic scan_check(input string tag);
        logic [3:0] prev;
        bit         found;
        disp_t      e;
        found = 1'b0;
        prev  = dig;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (dig == 4'b1110 && prev != 4'b1110) found = 1'b1;
            prev = dig;
        end
        if (!found) begin
            chk({tag, " scan_sync"}, 32'd0, 32'd1);
            sb_q.delete();
            return;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = sb_q.pop_front();
            chk({tag, " dig"}, 32'(dig), 32'(e.dig));
            chk({tag, " seg"}, 32'(seg), 32'(e.seg));
            if (i < 3) @(negedge clk);
        end
    endtask

    // Returns on the negedge right after the selection/freeze update.
    task automatic press(input logic [3:0] mask, input bit rel);
        logic old_f;
        bit   sel_evt;
        repeat (8) @(negedge clk);
        btn_n = btn_n & ~mask;
        repeat (7) @(negedge clk);
        old_f   = m_frozen;
        sel_evt = mask[0] | mask[1] | mask[3];
        if (mask[3])      m_sel = 0;
        else if (mask[0]) m_sel = (m_sel + 1) % NUM_CH;
        else if (mask[1]) m_sel = (m_sel + NUM_CH - 1) % NUM_CH;
        if (mask[2]) m_frozen = ~m_frozen;
        if (m_frozen && (sel_evt || !old_f)) m_snap = ch_word(m_sel);
        chk("sel_ch", 32'(sel_ch), 32'(m_sel));
        chk("frozen", 32'(frozen), 32'(m_frozen));
        if (rel) begin
            fork
                begin
                    repeat (3) @(negedge clk);
                    btn_n = 4'hF;
                end
            join_none
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ch_data = {16'h00AA, 16'hBEEF, 16'h1234};
        repeat (3) @(negedge clk);
        chk("rst seg", 32'(seg), 32'hFF);
        chk("rst dig", 32'(dig), 32'hF);
        chk("rst sel", 32'(sel_ch), 32'd0);
        chk("rst frozen", 32'(frozen), 32'd0);

        // 1: first enable lands SCAN_CYCLES+1 cycles after release
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("pre_enable dig", 32'(dig), 32'hF);
        @(negedge clk);
        chk("first_enable dig", 32'(dig), 32'hE);
        push_value();
        scan_check("t1");

        // 2: glitch is ignored, a real press increments once
        btn_n[0] = 1'b0;
        repeat (3) @(negedge clk);
        btn_n = 4'hF;
        repeat (12) @(negedge clk);
        chk("glitch sel", 32'(sel_ch), 32'd0);
        press(4'b0001, 1'b1);
        push_banner();
        scan_check("t2 banner");
        repeat (16) @(negedge clk);
        chk("single_inc sel", 32'(sel_ch), 32'd1);
        push_value();
        scan_check("t2 value");

        // 3: home, prev wrap, next wrap
        press(4'b1000, 1'b1);
        push_banner();
        scan_check("t3 home banner");
        repeat (16) @(negedge clk);
        press(4'b0010, 1'b1);
        push_banner();
        scan_check("t3 prev banner");
        repeat (16) @(negedge clk);
        push_value();
        scan_check("t3 value");
        press(4'b0001, 1'b1);
        repeat (16) @(negedge clk);

        // 4: freeze, snapshot recapture, unfreeze
        press(4'b0001, 1'b1);
        repeat (16) @(negedge clk);
        press(4'b0100, 1'b1);
        ch_data[31:16] = 16'h5555;
        push_value();
        scan_check("t4 frozen");
        press(4'b0001, 1'b1);
        push_banner();
        scan_check("t4 frozen banner");
        repeat (16) @(negedge clk);
        ch_data[47:32] = 16'h1111;
        push_value();
        scan_check("t4 snapshot");
        press(4'b0100, 1'b1);
        push_value();
        scan_check("t4 live");

        // 5: home beats next; home at 0 restarts the banner
        press(4'b0010, 1'b1);
        repeat (16) @(negedge clk);
        press(4'b1001, 1'b1);
        push_banner();
        scan_check("t5 home+next");
        repeat (20) @(negedge clk);
        push_value();
        scan_check("t5 value");
        press(4'b1000, 1'b1);
        push_banner();
        scan_check("t5 home again");
        repeat (16) @(negedge clk);

        // 6: async reset mid-banner while frozen with a button held
        press(4'b0100, 1'b1);
        press(4'b0001, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6 rst seg", 32'(seg), 32'hFF);
        chk("t6 rst dig", 32'(dig), 32'hF);
        chk("t6 rst frozen", 32'(frozen), 32'd0);
        chk("t6 rst sel", 32'(sel_ch), 32'd0);
        m_sel    = 0;
        m_frozen = 1'b0;
        m_snap   = 16'h0;
        @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        chk("t6 held sel", 32'(sel_ch), 32'd0);
        btn_n = 4'hF;
        repeat (12) @(negedge clk);
        press(4'b0001, 1'b1);
        push_banner();
        scan_check("t6 repress banner");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_view_scanner.md
Name: reg_view_scanner

Overview:
- Parametrised successor to the CPU register monitor. It observes NUM_CH 16-bit debug channels (PC, A, X, Y, SP, P, bus address, ...) and shows one of them on a 4-digit multiplexed 7-segment display.
- Four active-low buttons are debounced in-block and step through channels (next/prev/home) or freeze the shown value.
- Scanning and hex decode are internal; the block drives seg/dig pins directly.
- A short "C nn" banner identifies the channel after every selection change.

Parameters:
NUM_CH, 4, number of 16-bit channels; range 2..256.
DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before a debounced button state changes.
SCAN_CYCLES, 50000, clk cycles each digit is enabled.
BANNER_CYCLES, 25000000, clk cycles the channel banner is shown after a selection change.

Ports:
clk  in  1  system clock; all state on rising edge.
reset  in  1  asynchronous, active-low reset.
ch_data  in  NUM_CH*16  flat channel bus; channel k = ch_data[16k+15:16k].
btn_n  in  4  raw buttons, active-low, asynchronous: [0]=next, [1]=prev, [2]=freeze toggle, [3]=home (channel 0).
seg  out  8  active-low segments; [0]=a .. [6]=g, [7]=dp.
dig  out  4  active-low one-hot digit enable; dig[0] = rightmost (least-significant nibble).
sel_ch  out  CHW  selected channel index, CHW = max(1, clog2(NUM_CH)).
frozen  out  1  freeze active.

Behaviour:
- Reset (reset=0, asynchronous):
  - sel_ch=0, frozen=0, snapshot=0, banner inactive, scan index 0, scan counter 0.
  - seg=8'hFF, dig=4'hF.
  - Debounced button states = released (1); sync flops = 1.
- Input path:
  - Each btn_n bit passes through a 2-flop synchroniser, then a per-button counter.
  - The counter resets whenever the synchronised value equals the debounced state.
  - When the synchronised value has differed from the debounced state for DEBOUNCE_CYCLES consecutive cycles, the debounced state flips.
  - A 1->0 transition of a debounced state generates a one-cycle press event. Release generates no event.
- Selection, applied on the cycle after the event:
  - Priority: home > next > prev.
  - next: sel_ch+1, wrapping NUM_CH-1 -> 0.
  - prev: sel_ch-1, wrapping 0 -> NUM_CH-1.
  - home: 0, even if sel_ch is already 0.
  - Any selection event, including home to 0 and a wrap, (re)starts the banner counter at BANNER_CYCLES.
- Freeze:
  - A freeze event toggles frozen. Freeze is independent of, and may coincide with, selection events.
  - On 0->1, snapshot <= selected channel's current data. If a selection event coincides, snapshot takes the NEW channel's data.
  - While frozen, any selection change recaptures snapshot from the new channel once; it does not track afterwards.
  - Displayed value = frozen ? snapshot : live ch_data[sel_ch], sampled every cycle.
- Banner, while the banner counter is nonzero:
  - dig[3]='C' (a,d,e,f on), dig[2]=blank, dig[1]=sel_ch[7:4], dig[0]=sel_ch[3:0].
  - sel_ch is zero-extended to 8 bits.
  - The counter decrements every cycle; at 0 the display reverts to value mode.
- Value mode: dig[3..0] show nibbles [15:12]..[3:0] as standard hex glyphs 0-F (b and d lowercase).
- Decimal point: dp lit (seg[7]=0) only on digit 0 while frozen, in both modes.
- Scan:
  - The counter counts 0..SCAN_CYCLES-1. On wrap the scan index advances 0->1->2->3->0.
  - seg/dig are registered: the update lands one cycle after the index change.
  - The first enable is dig=4'b1110, at SCAN_CYCLES+1 cycles after reset release.
  - Exactly one dig bit is low at any time after the first enable.
- Reset mid-debounce, mid-banner or while frozen returns everything to reset values immediately. No event is generated on release of reset even if a button is held; the held button must be released and re-pressed.

Test Plan:
Use NUM_CH=3, DEBOUNCE_CYCLES=4, SCAN_CYCLES=2, BANNER_CYCLES=16 for all scenarios.
1. Reset, then ch_data={16'h00AA,16'hBEEF,16'h1234}, no buttons, run past banner-free scan -> dig cycles 1110,1101,1011,0111; seg = glyphs 4,3,2,1 respectively; sel_ch=0; dp off.
2. Pulse btn_n[0] low for 3 cycles (glitch), then hold low 10 cycles -> no change for the glitch; exactly one increment to sel_ch=1; banner "C 01" for 16 cycles, then "bEEF".
3. From sel_ch=0, press prev once -> sel_ch=2 (wrap), banner "C 02", then "00AA". Press next -> sel_ch=0 (wrap).
4. sel_ch=1, press freeze, then change ch_data[31:16] to 16'h5555 -> frozen=1, display stays "bEEF", dp lit on dig[0]. Press next -> snapshot "00AA" held while ch2 is changed. Press freeze again -> live tracking resumes, dp off.
5. Press next and home simultaneously from sel_ch=1 -> sel_ch=0 and banner restarts. Press home at sel_ch=0 -> banner shown again.
6. Assert reset mid-banner while frozen with btn_n[0] held low -> seg=FF, dig=F, frozen=0, sel_ch=0. After release with the button still held -> no increment until release and re-press.
